// File: rtl/ls_align_unit.sv
// Load/store alignment engine: sub-word extract/extend on loads, read-modify-write on sub-word stores.
// Latency: error 1 cycle, full store 2, load MEM_LAT+2, sub-word store MEM_LAT+3 (accept cycle = 0).
// Backpressure: none; req is sampled only when idle and ignored while busy (no queueing).
module ls_align_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LB    = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [LB-1:0]    lane_q;
    logic             err_q;

    logic [LB-1:0]    lane_in;
    logic             bad_req;
    logic [LB+2:0]    shamt;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] ins;
    logic [DATA_W-1:0] merged;

    // Strobes and status decode straight from state so reset drops them asynchronously
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign err    = (state == S_DONE) & err_q;
    assign mem_rd = (state == S_RD);
    assign mem_wr = (state == S_WR);

    assign lane_in = addr[LB-1:0];
    assign shamt   = {lane_q, 3'b000};

    // Classify the incoming request: reserved size, odd half address, or full access off a word boundary
    always_comb begin
        bad_req = 1'b0;
        case (size)
            2'b01:   bad_req = addr[0];
            2'b10:   bad_req = |lane_in;
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    end

    // Load path: bring addressed lane(s) down to bit 0, then sign- or zero-extend
    always_comb begin
        rd_shift = mem_rdata >> shamt;
        ext      = rd_shift;
        case (size_q)
            2'b00: begin
                ext      = {DATA_W{sign_q & rd_shift[7]}};
                ext[7:0] = rd_shift[7:0];
            end
            2'b01: begin
                ext       = {DATA_W{sign_q & rd_shift[15]}};
                ext[15:0] = rd_shift[15:0];
            end
            default: ext = rd_shift;
        endcase
    end

    // Store path: splice the store byte/half into the fetched word; mem_wdata still holds wdata here
    always_comb begin
        lane_mask = (size_q == 2'b00) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF);
        lane_mask = lane_mask << shamt;
        ins       = (size_q == 2'b00) ? DATA_W'(mem_wdata[7:0]) : DATA_W'(mem_wdata[15:0]);
        ins       = ins << shamt;
        merged    = (mem_rdata & ~lane_mask) | (ins & lane_mask);
    end

    // Control FSM with request latch, latency counter and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            lane_q    <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q      <= we;
                        size_q    <= size;
                        sign_q    <= sign_ext;
                        lane_q    <= lane_in;
                        err_q     <= bad_req;
                        mem_addr  <= addr & ~ADDR_W'((1 << LB) - 1);
                        mem_wdata <= wdata;
                        if (bad_req)
                            state <= S_DONE;
                        else if (we && size == 2'b10)
                            state <= S_WR;
                        else
                            state <= S_RD;
                    end
                end
                S_RD: begin
                    cnt   <= CNT_W'(1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(MEM_LAT)) begin
                        cnt <= '0;
                        if (we_q) begin
                            mem_wdata <= merged;
                            state     <= S_WR;
                        end else begin
                            rdata <= ext;
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_align_unit.sv
// Bench for ls_align_unit at DATA_W=32, MEM_LAT=2: scoreboarded ops with a latency-exact memory responder.
// Latency: each op tracked cycle-by-cycle from accept to done.
// Backpressure: none; also checks that req while busy is ignored.
module tb_ls_align_unit;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 2;
    localparam logic [31:0] GARB = 32'h5A5A_5A5A;

    logic          clock = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sign_ext;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = GARB;

    ls_align_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        int          done_c;
        int          rd_c;
        int          wr_c;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [31:0] maddr;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] mem_word = 32'h0;
    int          pend = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Memory returns the word only in the cycle it must be sampled, garbage otherwise
    always @(negedge clock) begin
        if (!reset) begin
            pend = 0;
            mem_rdata = GARB;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                mem_rdata = (pend == 0) ? mem_word : GARB;
            end else begin
                mem_rdata = GARB;
            end
            if (mem_rd) pend = LAT;
        end
    end

    // Reference behaviour written from the byte-lane view of the word
    function automatic exp_t model(input logic iwe, input logic [1:0] isz, input logic isx,
                                   input logic [31:0] iaddr, input logic [31:0] iwd,
                                   input logic [31:0] word, input logic [31:0] cur_rd);
        exp_t e;
        logic [7:0] b [4];
        int   ln;
        logic [31:0] sh;
        ln = int'(iaddr[1:0]);
        e.maddr = {iaddr[31:2], 2'b00};
        e.rdat  = cur_rd;
        e.wdat  = 32'h0;
        e.rd_c  = -1;
        e.wr_c  = -1;
        e.err   = (isz == 2'b11) || (isz == 2'b01 && iaddr[0]) || (isz == 2'b10 && ln != 0);
        if (e.err) begin
            e.done_c = 1;
        end else if (iwe && isz == 2'b10) begin
            e.wr_c = 1; e.done_c = 2; e.wdat = iwd;
        end else if (iwe) begin
            for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
            b[ln] = iwd[7:0];
            if (isz == 2'b01) b[ln+1] = iwd[15:8];
            e.rd_c = 1; e.wr_c = LAT + 2; e.done_c = LAT + 3;
            e.wdat = {b[3], b[2], b[1], b[0]};
        end else begin
            e.rd_c = 1; e.done_c = LAT + 2;
            sh = word >> (8 * ln);
            if (isz == 2'b00)      e.rdat = {{24{isx & sh[7]}}, sh[7:0]};
            else if (isz == 2'b01) e.rdat = {{16{isx & sh[15]}}, sh[15:0]};
            else                   e.rdat = word;
        end
        return e;
    endfunction

    task automatic run_op(input logic iwe, input logic [1:0] isz, input logic isx,
                          input logic [31:0] iaddr, input logic [31:0] iwd,
                          input logic [31:0] word, input bit hold);
        exp_t e;
        int   rd_n, wr_n, rd_c, wr_c, done_c;
        logic errv, busy_ok, err_stray;
        logic [31:0] wv, rdv, mav;
        @(negedge clock);
        chk("idle_busy", {63'b0, busy}, 64'd0);
        expq.push_back(model(iwe, isz, isx, iaddr, iwd, word, m_rdata));
        mem_word = word;
        req = 1'b1; we = iwe; size = isz; sign_ext = isx; addr = iaddr; wdata = iwd;
        rd_n = 0; wr_n = 0; rd_c = -1; wr_c = -1; done_c = -1;
        errv = 1'b0; busy_ok = 1'b1; err_stray = 1'b0;
        wv = 32'h0; rdv = 32'h0; mav = 32'h0;
        for (int c = 1; c <= 30 && done_c < 0; c++) begin
            @(negedge clock);
            if (c == 1) begin
                mav = mem_addr;
                if (!hold) req = 1'b0;
                else begin size = 2'b11; addr = 32'h3FF; end
            end
            if (mem_rd) begin rd_n++; rd_c = c; end
            if (mem_wr) begin wr_n++; wr_c = c; wv = mem_wdata; end
            if (!busy) busy_ok = 1'b0;
            if (err && !done) err_stray = 1'b1;
            if (done) begin done_c = c; errv = err; rdv = rdata; end
        end
        req = 1'b0;
        e = expq.pop_front();
        chk("done_cyc", 64'(done_c), 64'(e.done_c));
        chk("err", {63'b0, errv}, {63'b0, e.err});
        chk("rd_cyc", 64'(rd_c), 64'(e.rd_c));
        chk("rd_cnt", 64'(rd_n), (e.rd_c < 0) ? 64'd0 : 64'd1);
        chk("wr_cyc", 64'(wr_c), 64'(e.wr_c));
        chk("wr_cnt", 64'(wr_n), (e.wr_c < 0) ? 64'd0 : 64'd1);
        if (e.wr_c >= 0) chk("wdata", {32'b0, wv}, {32'b0, e.wdat});
        chk("rdata", {32'b0, rdv}, {32'b0, e.rdat});
        chk("maddr", {32'b0, mav}, {32'b0, e.maddr});
        chk("busy_span", {63'b0, busy_ok}, 64'd1);
        chk("err_stray", {63'b0, err_stray}, 64'd0);
        m_rdata = e.rdat;
    endtask

    int dn;

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        #3;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_err", {63'b0, err}, 64'd0);
        chk("rst_rd", {63'b0, mem_rd}, 64'd0);
        chk("rst_wr", {63'b0, mem_wr}, 64'd0);
        chk("rst_rdata", {32'b0, rdata}, 64'd0);
        chk("rst_maddr", {32'b0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'b0, mem_wdata}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 1'b0);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'h80FF1234, 1'b0);
        run_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'h80FF1234, 1'b0);
        run_op(1'b1, 2'b00, 1'b0, 32'h101, 32'hAB,       32'h11223344, 1'b0);
        run_op(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0,        1'b0);
        run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        32'h80FF1234, 1'b0);
        run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h80FF1234, 1'b0);
        run_op(1'b1, 2'b11, 1'b0, 32'h104, 32'h77,       32'h80FF1234, 1'b0);
        run_op(1'b0, 2'b10, 1'b1, 32'h204, 32'h0,        32'hCAFEF00D, 1'b0);
        run_op(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234BEEF, 32'hAABBCCDD, 1'b0);
        run_op(1'b0, 2'b00, 1'b0, 32'h102, 32'h0,        32'h80FF1234, 1'b0);
        run_op(1'b0, 2'b10, 1'b0, 32'h202, 32'h0,        32'h80FF1234, 1'b0);

        // Reset while waiting on memory aborts the load with no completion
        @(negedge clock);
        mem_word = 32'h12345678;
        req = 1'b1; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h103;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        chk("arst_rd", {63'b0, mem_rd}, 64'd0);
        chk("arst_wr", {63'b0, mem_wr}, 64'd0);
        chk("arst_rdata", {32'b0, rdata}, 64'd0);
        m_rdata = 32'h0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) dn++;
        end
        reset = 1'b1;
        chk("arst_nodone", 64'(dn), 64'd0);
        run_op(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000C300, 1'b0);

        // req held high through a busy load must not start a second op
        run_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h000000E5, 1'b1);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done) dn++;
        end
        chk("busy_req_ignored", 64'(dn), 64'd0);
        chk("busy_after", {63'b0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
